// File: rtl/serial_add_controller.sv
// Bit-serial add controller: shifts parallel operands LSB-first into an external serial adder and reassembles the sum.
// Optional macro SERIAL_ADD_BACK_TO_BACK_EN lets a new word be accepted during the last-bit cycle.
module serial_add_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_clear,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_sum,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;
  logic             accept;

  always_comb begin
    last_bit = (state == SHIFT) && (cnt == LAST_BIT);
`ifdef SERIAL_ADD_BACK_TO_BACK_EN
    in_ready = !rst && ((state == IDLE) || last_bit);
`else
    in_ready = !rst && (state == IDLE);
`endif
    accept    = in_valid && in_ready;
    ser_clear = accept;
    // Outputs are gated by rst because reset is synchronous and state may still read SHIFT.
    ser_valid = !rst && (state == SHIFT);
    ser_last  = !rst && last_bit;
    ser_a     = ser_valid && sh_a[0];
    ser_b     = ser_valid && sh_b[0];
    // res holds bits 0..k-1 MSB-aligned; prepending the live bit forms the next window.
    res_next  = {ser_sum, res};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = accept ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      res       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      state     <= state_next;
      out_valid <= ser_last;
      if (accept) begin
        sh_a <= in_a;
        sh_b <= in_b;
        cnt  <= '0;
      end else if (ser_valid) begin
        sh_a <= sh_a >> 1;
        sh_b <= sh_b >> 1;
        cnt  <= last_bit ? '0 : cnt + CW'(1);
      end
      if (ser_valid) res <= res_next[WIDTH-1:1];
      if (ser_last) out_sum <= res_next;
    end
  end

endmodule

// File: doc/serial_add_controller.md
SERIAL_ADD_CONTROLLER -- requirements
Module: serial_add_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result word width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk input 1 as the single clock; all logic on posedge clk.
REQ-003 SHALL have port rst input 1 as the reset; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid input 1: parallel operand word offered.
REQ-005 SHALL have port in_ready output 1: controller can accept a word this cycle.
REQ-006 SHALL have ports in_a and in_b, each input WIDTH: parallel operands.
REQ-007 SHALL have ports ser_a and ser_b, each output 1: serial operand bits to the serial adder, LSB first.
REQ-008 SHALL have port ser_clear output 1: carry-clear strobe to the serial adder's reset input.
REQ-009 SHALL have port ser_valid output 1: ser_a/ser_b carry a valid bit this cycle.
REQ-010 SHALL have port ser_last output 1: current serial bit is bit WIDTH-1.
REQ-011 SHALL have port ser_sum input 1: combinational sum bit returned by the serial adder in the same cycle.
REQ-012 SHALL have port out_valid output 1: single-cycle result strobe.
REQ-013 SHALL have port out_sum output WIDTH: assembled parallel sum.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT, with a bit counter of width $clog2(WIDTH).
REQ-015 SHALL treat a word as accepted in cycle T when in_valid && in_ready; in_a/in_b are captured into shift registers at the end of T.
REQ-016 SHALL assert ser_clear combinationally equal to the accept condition, so the adder carry is zero for the first bit.
REQ-017 SHALL present bit i of in_a/in_b on ser_a/ser_b with ser_valid=1 in cycle T+1+i, for i = 0..WIDTH-1.
REQ-018 SHALL assert ser_last only in cycle T+WIDTH.
REQ-019 SHALL drive ser_a, ser_b and ser_valid to 0 whenever no bit is being emitted.
REQ-020 SHALL sample ser_sum on every cycle with ser_valid=1 into result bit i.
REQ-021 SHALL load out_sum with the completed result and pulse out_valid for exactly one cycle at T+WIDTH+1.
REQ-022 SHALL hold out_sum unchanged until the next out_valid; there is no output backpressure.
REQ-023 SHALL implement modulo-2^WIDTH arithmetic: the final carry is discarded, with no overflow output.
REQ-024 SHALL assert in_ready in IDLE and deassert it in SHIFT, except as in REQ-029.
REQ-025 SHALL not sample or disturb a word offered while in_ready=0; it stays pending and is accepted when in_ready rises.
REQ-026 SHALL make transitions IDLE->SHIFT on accept; SHIFT->IDLE after the ser_last cycle, unless a back-to-back accept occurs.

Reset
REQ-027 SHALL, while rst=1, drive in_ready=0, ser_a=0, ser_b=0, ser_valid=0, ser_last=0, ser_clear=0, out_valid=0, out_sum=0, counter=0, state IDLE.
REQ-028 SHALL, on rst mid-word, discard the partial result, produce no out_valid for it, and present in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-029 SHALL support macro SERIAL_ADD_BACK_TO_BACK_EN. When defined, in_ready is also 1 during the ser_last cycle; an accept there asserts ser_clear, re-enters SHIFT and emits the new bit 0 in the next cycle, giving one word per WIDTH cycles. When undefined, in_ready is 1 only in IDLE, giving one word per WIDTH+1 cycles.

Verification
REQ-030 SHALL cover: WIDTH=8, in_a=0x35, in_b=0x4A accepted at T -> ser_clear=1 at T, ser_a bits 1,0,1,0,1,1,0,0 over T+1..T+8, out_valid at T+9, out_sum=0x7F.
REQ-031 SHALL cover: 0xFF + 0x01 -> out_sum=0x00 (wrap, carry dropped), then 0x80 + 0x80 -> 0x00, proving ser_clear zeroed the carry between words.
REQ-032 SHALL cover: in_valid held high with 0x11/0x22 while busy -> single accept only, in_ready=0 for cycles T+1..T+8; macro off -> next accept at T+9.
REQ-033 SHALL cover, macro on: continuous in_valid with 0x01+0x02 then 0x10+0x20 -> second ser_clear coincides with the first ser_last, second bit 0 at T+9, out_sum 0x03 at T+9 and 0x30 at T+17.
REQ-034 SHALL cover: rst pulsed at T+4 mid-word -> no out_valid, out_sum=0; next word 0x0F+0x01 -> out_sum=0x10.
REQ-035 SHALL cover: WIDTH=4, 0x9+0x9 -> out_sum=0x2, out_valid at T+5.
